vec_execute_unit: RTL and testbench

//  Consumer side of the Decode->Execute pipeline register: takes the registered opcode,

---
 rtl/vec_cpu_pkg.sv | 39 +++
 rtl/vec_lane_alu.sv | 25 ++
 rtl/vec_execute_unit.sv | 145 ++++++++++++++
 tb/tb_vec_execute_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_cpu_pkg.sv
// Shared types for the vector CPU execute stage: opcodes, FSM states and the
// writeback packet that leaves the execute unit.
package vec_cpu_pkg;

  localparam int LANES  = 8;
  localparam int LANE_W = 8;
  localparam int VEC_W  = LANES * LANE_W;
  localparam int CNT_W  = $clog2(LANES);

  typedef enum logic [4:0] {
    OP_VADD  = 5'b00000,
    OP_VSUB  = 5'b00001,
    OP_VXOR  = 5'b00010,
    OP_VMULI = 5'b00011,
    OP_VSHLI = 5'b00100,
    OP_ADD   = 5'b01000,
    OP_ADDI  = 5'b01001,
    OP_NOP   = 5'b10100
  } opcode_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  // "reg" is a keyword, so the destination index field is called rd.
  typedef struct packed {
    logic              valid;
    logic              is_vector;
    logic [2:0]        rd;
    logic [31:0]       scalar;
    logic [VEC_W-1:0]  vec;
  } wb_pkt_t;

  function automatic logic is_lane_op(input logic [4:0] op);
    return (op == OP_VADD) || (op == OP_VSUB) || (op == OP_VXOR) || (op == OP_VSHLI);
  endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// Combinational single-lane ALU; results wrap modulo 2^LANE_W so no carry
// ever leaves the lane.
module vec_lane_alu
  import vec_cpu_pkg::*;
(
  input  logic [4:0]        i_opcode,
  input  logic [LANE_W-1:0] i_a,
  input  logic [LANE_W-1:0] i_b,
  input  logic [2:0]        i_shamt,
  output logic [LANE_W-1:0] o_result
);

  always_comb begin
    o_result = '0;
    case (i_opcode)
      OP_VADD:  o_result = i_a + i_b;
      OP_VSUB:  o_result = i_a - i_b;
      OP_VXOR:  o_result = i_a ^ i_b;
      OP_VSHLI: o_result = i_a << i_shamt;
      OP_VMULI: o_result = i_a * i_b;
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/vec_execute_unit.sv
// Execute stage: single-cycle vector/scalar ops plus an iterative lane-serial
// VMULI that holds the Decode->Execute register via stall while it runs.
module vec_execute_unit
  import vec_cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [4:0]        opcode,
  input  logic [31:0]       reg1_data,
  input  logic [31:0]       reg2_data,
  input  logic [7:0]        immediate,
  input  logic [VEC_W-1:0]  vec1_data,
  input  logic [VEC_W-1:0]  vec2_data,
  input  logic [2:0]        wb_register,
  output logic              stall,
  output logic              wb_valid,
  output logic              wb_is_vector,
  output logic [2:0]        wb_reg,
  output logic [31:0]       wb_scalar_data,
  output logic [VEC_W-1:0]  wb_vec_data
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LANES - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [VEC_W-1:0]   r_mul_vec;
  logic [VEC_W-1:0]   r_acc;
  logic [7:0]         r_mul_imm;
  logic [2:0]         r_mul_reg;
  wb_pkt_t            r_pkt;

  logic [VEC_W-1:0]   w_lane_vec;
  logic [LANE_W-1:0]  w_mul_a;
  logic [LANE_W-1:0]  w_mul_lane;
  logic [VEC_W-1:0]   w_mul_final;
  wb_pkt_t            w_idle_pkt;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      vec_lane_alu u_lane_alu (
        .i_opcode (opcode),
        .i_a      (vec1_data[gi*LANE_W +: LANE_W]),
        .i_b      (vec2_data[gi*LANE_W +: LANE_W]),
        .i_shamt  (immediate[2:0]),
        .o_result (w_lane_vec[gi*LANE_W +: LANE_W])
      );
    end
  endgenerate

  // One shared lane multiplier walks the latched operand lane by lane.
  assign w_mul_a = r_mul_vec[r_cnt*LANE_W +: LANE_W];

  vec_lane_alu u_mul_alu (
    .i_opcode (OP_VMULI),
    .i_a      (w_mul_a),
    .i_b      (r_mul_imm),
    .i_shamt  (3'd0),
    .o_result (w_mul_lane)
  );

  // Completion happens with cnt on the top lane, so the final lane bypasses r_acc.
  assign w_mul_final = {w_mul_lane, r_acc[VEC_W-LANE_W-1:0]};

  always_comb begin
    w_idle_pkt = '0;
    if (is_lane_op(opcode)) begin
      w_idle_pkt.valid     = 1'b1;
      w_idle_pkt.is_vector = 1'b1;
      w_idle_pkt.rd        = wb_register;
      w_idle_pkt.vec       = w_lane_vec;
    end else if (opcode == OP_ADD) begin
      w_idle_pkt.valid  = 1'b1;
      w_idle_pkt.rd     = wb_register;
      w_idle_pkt.scalar = reg1_data + reg2_data;
    end else if (opcode == OP_ADDI) begin
      w_idle_pkt.valid  = 1'b1;
      w_idle_pkt.rd     = wb_register;
      w_idle_pkt.scalar = reg1_data + {{24{immediate[7]}}, immediate};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_mul_vec <= '0;
      r_acc     <= '0;
      r_mul_imm <= '0;
      r_mul_reg <= '0;
      r_pkt     <= '0;
    end else if (flush) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_pkt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_pkt <= w_idle_pkt;
          if (opcode == OP_VMULI) begin
            r_mul_vec <= vec1_data;
            r_mul_imm <= immediate;
            r_mul_reg <= wb_register;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_state   <= MUL;
          end
        end
        MUL: begin
          r_acc[r_cnt*LANE_W +: LANE_W] <= w_mul_lane;
          r_cnt <= r_cnt + CNT_W'(1);
          r_pkt <= '0;
          if (r_cnt == CNT_LAST) begin
            r_pkt.valid     <= 1'b1;
            r_pkt.is_vector <= 1'b1;
            r_pkt.rd        <= r_mul_reg;
            r_pkt.vec       <= w_mul_final;
            r_cnt           <= '0;
            r_state         <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_pkt   <= '0;
        end
      endcase
    end
  end

  // Low on the last MUL cycle so the held instruction advances exactly as the packet lands.
  assign stall = !reset && !flush &&
                 (((r_state == IDLE) && (opcode == OP_VMULI)) ||
                  ((r_state == MUL) && (r_cnt != CNT_LAST)));

  assign wb_valid       = r_pkt.valid;
  assign wb_is_vector   = r_pkt.is_vector;
  assign wb_reg         = r_pkt.rd;
  assign wb_scalar_data = r_pkt.scalar;
  assign wb_vec_data    = r_pkt.vec;

endmodule

// File: tb/tb_vec_execute_unit.sv
// Scoreboard bench: expected packets are queued with their due cycle when an op
// is presented and matched against the DUT's writeback port each cycle.
module tb_vec_execute_unit;
  import vec_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [4:0]  opcode = OP_NOP;
  logic [31:0] reg1_data = '0;
  logic [31:0] reg2_data = '0;
  logic [7:0]  immediate = '0;
  logic [63:0] vec1_data = '0;
  logic [63:0] vec2_data = '0;
  logic [2:0]  wb_register = '0;
  logic        stall;
  logic        wb_valid;
  logic        wb_is_vector;
  logic [2:0]  wb_reg;
  logic [31:0] wb_scalar_data;
  logic [63:0] wb_vec_data;

  typedef struct {
    bit          valid;
    bit          is_vec;
    logic [2:0]  rd;
    logic [31:0] scal;
    logic [63:0] vec;
    int          due;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  vec_execute_unit dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .opcode         (opcode),
    .reg1_data      (reg1_data),
    .reg2_data      (reg2_data),
    .immediate      (immediate),
    .vec1_data      (vec1_data),
    .vec2_data      (vec2_data),
    .wb_register    (wb_register),
    .stall          (stall),
    .wb_valid       (wb_valid),
    .wb_is_vector   (wb_is_vector),
    .wb_reg         (wb_reg),
    .wb_scalar_data (wb_scalar_data),
    .wb_vec_data    (wb_vec_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic exp_t mk_vec(input logic [2:0] rd, input logic [63:0] v);
    exp_t e = '{default: 0};
    e.valid = 1'b1; e.is_vec = 1'b1; e.rd = rd; e.vec = v;
    return e;
  endfunction

  function automatic exp_t mk_scal(input logic [2:0] rd, input logic [31:0] s);
    exp_t e = '{default: 0};
    e.valid = 1'b1; e.rd = rd; e.scal = s;
    return e;
  endfunction

  function automatic exp_t model(input logic [4:0] op, input logic [31:0] r1, input logic [31:0] r2,
                                 input logic [7:0] imm, input logic [63:0] v1, input logic [63:0] v2,
                                 input logic [2:0] rd);
    exp_t e = '{default: 0};
    logic [63:0] v = '0;
    logic [7:0]  a, b;
    if (op == OP_VADD || op == OP_VSUB || op == OP_VXOR || op == OP_VSHLI || op == OP_VMULI) begin
      for (int i = 0; i < 8; i++) begin
        a = v1[8*i +: 8];
        b = v2[8*i +: 8];
        case (op)
          OP_VADD:  v[8*i +: 8] = 8'(a + b);
          OP_VSUB:  v[8*i +: 8] = 8'(a - b);
          OP_VXOR:  v[8*i +: 8] = a ^ b;
          OP_VSHLI: v[8*i +: 8] = 8'(a << imm[2:0]);
          default:  v[8*i +: 8] = 8'(a * imm);
        endcase
      end
      e = mk_vec(rd, v);
    end else if (op == OP_ADD) begin
      e = mk_scal(rd, r1 + r2);
    end else if (op == OP_ADDI) begin
      e = mk_scal(rd, r1 + 32'(signed'(imm)));
    end
    return e;
  endfunction

  // Presents one instruction and holds it while stall is high, as the pipeline register would.
  task automatic issue(input logic [4:0] op, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [7:0] imm, input logic [63:0] v1, input logic [63:0] v2,
                       input logic [2:0] rd, input exp_t e);
    int k = 0;
    opcode = op; reg1_data = r1; reg2_data = r2; immediate = imm;
    vec1_data = v1; vec2_data = v2; wb_register = rd;
    if (e.valid) begin
      e.due = cyc + ((op == OP_VMULI) ? 9 : 1);
      q.push_back(e);
    end
    $display("op=%b rd=%0d r1=%h r2=%h imm=%h v1=%h v2=%h at cyc %0d", op, rd, r1, r2, imm, v1, v2, cyc);
    forever begin
      @(negedge clk);
      check_val("stall", stall, (op == OP_VMULI) && (k < 8));
      if (!stall) break;
      k++;
      if (k > 12) begin
        check_val("stall_timeout", 1, 0);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    opcode = OP_NOP;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_valid"}, wb_valid, 0);
    check_val({tag, "_isvec"}, wb_is_vector, 0);
    check_val({tag, "_reg"}, wb_reg, 0);
    check_val({tag, "_scal"}, wb_scalar_data, 0);
    check_val({tag, "_vec"}, wb_vec_data, 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0 && q[0].due < cyc) begin
        check_val("missing_pkt", 0, 1);
        void'(q.pop_front());
      end
      if (wb_valid) begin
        if (q.size() == 0) begin
          check_val("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check_val("due_cycle", 64'(cyc), 64'(e.due));
          check_val("is_vector", wb_is_vector, e.is_vec);
          check_val("wb_reg", wb_reg, e.rd);
          check_val("scalar", wb_scalar_data, e.scal);
          check_val("vec", wb_vec_data, e.vec);
          $display("pkt cyc=%0d vec=%0b rd=%0d scal=%h v=%h", cyc, wb_is_vector, wb_reg, wb_scalar_data, wb_vec_data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] ops [11];
    exp_t none;
    none = '{default: 0};
    ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01001,
            5'b00011, 5'b10100, 5'b11111, 5'b00101, 5'b00111};

    // Reset with VMULI on the bus: stall must stay low and outputs cleared.
    opcode = OP_VMULI;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_stall", stall, 0);
    check_quiet("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    opcode = OP_NOP;
    mon_en = 1'b1;

    issue(OP_VADD, 0, 0, 0, 64'h01FF_0203_0405_0607, 64'h0101_0101_0101_0101, 3,
          mk_vec(3, 64'h0200_0304_0506_0708));
    issue(OP_ADDI, 32'd10, 0, 8'hFE, 0, 0, 1, mk_scal(1, 32'd8));
    idle_cycles(2);
    issue(OP_VMULI, 0, 0, 8'h11, 64'h0102_0304_0506_0710, 0, 5,
          mk_vec(5, 64'h1122_3344_5566_7710));
    issue(OP_ADD, 32'd5, 32'd7, 0, 0, 0, 2, mk_scal(2, 32'd12));
    issue(OP_VSHLI, 0, 0, 8'h03, 64'hFF81_4021_1008_0402, 0, 6,
          mk_vec(6, 64'hF808_0008_8040_2010));
    issue(OP_VSUB, 0, 0, 0, 64'h0000_0010_2030_4050, 64'h0101_0101_0101_0101, 7,
          mk_vec(7, 64'hFFFF_FF0F_1F2F_3F4F));
    idle_cycles(3);

    // Flush at T+4 of a VMULI: op dropped, no packet, unit back in IDLE.
    opcode = OP_VMULI; immediate = 8'h03; vec1_data = 64'h0102_0304_0506_0708; wb_register = 4;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("flush_pre_stall", stall, 1);
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    check_val("flush_stall", stall, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    opcode = OP_NOP;
    repeat (6) begin
      @(negedge clk);
      check_val("post_flush_stall", stall, 0);
      @(posedge clk); #1;
    end
    issue(OP_ADD, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, 4, mk_scal(4, 32'd1));

    // Reset mid-MUL: no packet for the aborted op.
    opcode = OP_VMULI; immediate = 8'h05; vec1_data = 64'h1111_1111_1111_1111;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(negedge clk);
    check_val("midrst_stall", stall, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    opcode = OP_NOP;
    @(negedge clk);
    check_quiet("midrst");
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      opcode = (k % 2 == 0) ? 5'b11111 : OP_NOP;
      @(negedge clk);
      check_val("undef_stall", stall, 0);
      check_quiet("undef");
    end
    @(posedge clk); #1;

    // Random mix, including back-to-back and undefined opcodes.
    for (int n = 0; n < 40; n++) begin
      logic [4:0]  op;
      logic [31:0] r1, r2;
      logic [7:0]  imm;
      logic [63:0] v1, v2;
      logic [2:0]  rd;
      op  = ops[$urandom_range(0, 10)];
      r1  = $urandom; r2 = $urandom; imm = 8'($urandom);
      v1  = {$urandom, $urandom}; v2 = {$urandom, $urandom};
      rd  = 3'($urandom);
      issue(op, r1, r2, imm, v1, v2, rd, model(op, r1, r2, imm, v1, v2, rd));
      if (n % 7 == 3) idle_cycles(1);
    end

    idle_cycles(12);
    check_val("queue_drain", 64'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
